axi_addr_router: RTL and testbench

Parametrised 1-to-N AXI4 address router for the LSU (or any single master) port of a nox SoC top. It replaces the hand-written two-target read mux with a generic block. Reads and writes are decoded independently against a base/mask map, and per-direction outstanding counters keep responses ordered. Unmapped addresses are answered by an internal decode-error responder.

---
 rtl/nox_utils_pkg.sv | 73 +++++++
 rtl/axi_decerr_slave.sv | 113 +++++++++++
 rtl/axi_addr_router.sv | 170 +++++++++++++++++
 tb/tb_axi_addr_router.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nox_utils_pkg.sv
// nox_utils_pkg: shared AXI4 types and helpers for the nox SoC interconnect.
//   s_axi_mosi_t / s_axi_miso_t : flattened AXI4 master->slave / slave->master bundles
//   axi_cnt_t                   : outstanding-transaction counter for the default depth
//   axi_tgt_t                   : router target index (slaves 0..7 plus the DECERR responder)
//   axi_addr_decode()           : base/mask address decoder, lowest matching index wins
package nox_utils_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int MAX_SLV     = 8;
    localparam int MAX_OUT_DEF = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef logic [$clog2(MAX_OUT_DEF+1)-1:0] axi_cnt_t;
    typedef logic [3:0]                       axi_tgt_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ID_W-1:0]     arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arvalid;
        logic                    rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_ID_W-1:0]   bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_ID_W-1:0]   rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } s_axi_miso_t;

    // Returns the lowest slave index whose masked base matches, or n when
    // nothing matches (n is the DECERR responder slot).
    function automatic axi_tgt_t axi_addr_decode(
        input logic [AXI_ADDR_W-1:0]               addr,
        input logic [MAX_SLV-1:0][AXI_ADDR_W-1:0]  base,
        input logic [MAX_SLV-1:0][AXI_ADDR_W-1:0]  mask,
        input int                                  n
    );
        axi_tgt_t idx;
        idx = axi_tgt_t'(n);
        // Scan downwards so the lowest match is the last one written.
        for (int i = MAX_SLV-1; i >= 0; i--) begin
            if ((i < n) && ((addr & mask[i]) == base[i]))
                idx = axi_tgt_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: answers every transaction with DECERR, one per direction at a time.
//   clk, arst   : clock, asynchronous active-high reset
//   axi_mosi_i  : request from the router
//   axi_miso_o  : response to the router (all handshake outputs registered)
// Reads return arlen+1 zero beats with rresp=DECERR; writes swallow W up to
// wlast and then return one B with bresp=DECERR.
module axi_decerr_slave
    import nox_utils_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o
);

    typedef enum logic       {RD_IDLE, RD_BURST}         rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t           rd_state_ff;
    logic                ar_rdy_ff, r_vld_ff, r_last_ff;
    logic [7:0]          r_rem_ff;
    logic [AXI_ID_W-1:0] r_id_ff;

    wr_state_t           wr_state_ff;
    logic                aw_rdy_ff, w_rdy_ff, b_vld_ff;
    logic [AXI_ID_W-1:0] b_id_ff;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_state_ff <= RD_IDLE;
            ar_rdy_ff   <= 1'b1;
            r_vld_ff    <= 1'b0;
            r_last_ff   <= 1'b0;
            r_rem_ff    <= '0;
            r_id_ff     <= '0;
        end else begin
            case (rd_state_ff)
                RD_IDLE: if (axi_mosi_i.arvalid && ar_rdy_ff) begin
                    rd_state_ff <= RD_BURST;
                    ar_rdy_ff   <= 1'b0;
                    r_vld_ff    <= 1'b1;
                    r_last_ff   <= (axi_mosi_i.arlen == 8'd0);
                    r_rem_ff    <= axi_mosi_i.arlen;
                    r_id_ff     <= axi_mosi_i.arid;
                end
                RD_BURST: if (axi_mosi_i.rready) begin
                    if (r_last_ff) begin
                        rd_state_ff <= RD_IDLE;
                        ar_rdy_ff   <= 1'b1;
                        r_vld_ff    <= 1'b0;
                        r_last_ff   <= 1'b0;
                    end else begin
                        r_rem_ff  <= r_rem_ff - 8'd1;
                        r_last_ff <= (r_rem_ff == 8'd1);
                    end
                end
                default: rd_state_ff <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_state_ff <= WR_IDLE;
            aw_rdy_ff   <= 1'b1;
            w_rdy_ff    <= 1'b0;
            b_vld_ff    <= 1'b0;
            b_id_ff     <= '0;
        end else begin
            case (wr_state_ff)
                WR_IDLE: if (axi_mosi_i.awvalid && aw_rdy_ff) begin
                    wr_state_ff <= WR_DATA;
                    aw_rdy_ff   <= 1'b0;
                    w_rdy_ff    <= 1'b1;
                    b_id_ff     <= axi_mosi_i.awid;
                end
                WR_DATA: if (axi_mosi_i.wvalid && axi_mosi_i.wlast) begin
                    wr_state_ff <= WR_RESP;
                    w_rdy_ff    <= 1'b0;
                    b_vld_ff    <= 1'b1;
                end
                WR_RESP: if (axi_mosi_i.bready) begin
                    wr_state_ff <= WR_IDLE;
                    b_vld_ff    <= 1'b0;
                    aw_rdy_ff   <= 1'b1;
                end
                default: wr_state_ff <= WR_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.arready = ar_rdy_ff;
        axi_miso_o.rvalid  = r_vld_ff;
        axi_miso_o.rlast   = r_last_ff;
        axi_miso_o.rid     = r_id_ff;
        axi_miso_o.rresp   = AXI_RESP_DECERR;
        axi_miso_o.rdata   = '0;
        axi_miso_o.awready = aw_rdy_ff;
        axi_miso_o.wready  = w_rdy_ff;
        axi_miso_o.bvalid  = b_vld_ff;
        axi_miso_o.bid     = b_id_ff;
        axi_miso_o.bresp   = AXI_RESP_DECERR;
    end

    // Payload fields the responder never looks at.
    logic unused;
    assign unused = ^{axi_mosi_i.awaddr, axi_mosi_i.awlen, axi_mosi_i.awsize,
                      axi_mosi_i.awburst, axi_mosi_i.wdata, axi_mosi_i.wstrb,
                      axi_mosi_i.araddr, axi_mosi_i.arsize, axi_mosi_i.arburst};

endmodule

// File: rtl/axi_addr_router.sv
// axi_addr_router: 1-to-N AXI4 address router with an internal DECERR target.
//   clk, arst       : clock, asynchronous active-high reset
//   mst_axi_mosi_i  : request from the single master
//   mst_axi_miso_o  : response to the master
//   slv_axi_mosi_o  : per-slave requests (valid/ready only on the selected slave)
//   slv_axi_miso_i  : per-slave responses
//   dec_err_o       : registered one-cycle pulse after an AR/AW to an unmapped address
// Reads and writes are decoded independently. A direction may only switch
// target once its outstanding count has drained to zero, so responses from
// different slaves never interleave and IDs stay ordered without a table.
module axi_addr_router
    import nox_utils_pkg::*;
#(
    parameter int N_SLAVES = 3,
    parameter int MAX_OUT  = 4,
    parameter logic [N_SLAVES-1:0][31:0] SLV_BASE = {32'h2000_0000, 32'h1000_0000, 32'h8000_0000},
    parameter logic [N_SLAVES-1:0][31:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                       clk,
    input  logic                       arst,
    input  s_axi_mosi_t                mst_axi_mosi_i,
    output s_axi_miso_t                mst_axi_miso_o,
    output s_axi_mosi_t [N_SLAVES-1:0] slv_axi_mosi_o,
    input  s_axi_miso_t [N_SLAVES-1:0] slv_axi_miso_i,
    output logic                       dec_err_o
);

    localparam int CNT_W = $clog2(MAX_OUT+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam axi_tgt_t DEC_IDX = axi_tgt_t'(N_SLAVES);
    localparam logic [MAX_SLV-1:0][31:0] BASE_PAD = (MAX_SLV*32)'(SLV_BASE);
    localparam logic [MAX_SLV-1:0][31:0] MASK_PAD = (MAX_SLV*32)'(SLV_MASK);

    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t     rd_cnt_ff, wr_cnt_ff, w_pend_ff;
    axi_tgt_t rd_tgt_ff, wr_tgt_ff;

    // Index N_SLAVES is the DECERR responder.
    s_axi_mosi_t [N_SLAVES:0] tgt_mosi;
    s_axi_miso_t [N_SLAVES:0] tgt_miso;
    s_axi_miso_t              dec_miso;

    axi_tgt_t ar_dec, aw_dec, w_tgt;
    logic     ar_ok, aw_ok, w_open;
    logic     ar_rdy_sel, aw_rdy_sel, w_rdy_sel;
    logic     ar_hs, aw_hs, r_done, w_done, b_done;

    logic                  r_vld_sel, r_last_sel, b_vld_sel;
    logic [AXI_ID_W-1:0]   r_id_sel, b_id_sel;
    logic [AXI_DATA_W-1:0] r_data_sel;
    logic [1:0]            r_resp_sel, b_resp_sel;

    assign tgt_miso = {dec_miso, slv_axi_miso_i};

    // Decode and accept gating
    always_comb begin
        ar_dec = axi_addr_decode(mst_axi_mosi_i.araddr, BASE_PAD, MASK_PAD, N_SLAVES);
        aw_dec = axi_addr_decode(mst_axi_mosi_i.awaddr, BASE_PAD, MASK_PAD, N_SLAVES);
        ar_ok  = ((rd_cnt_ff == '0) || (ar_dec == rd_tgt_ff)) && (rd_cnt_ff < CNT_MAX);
        aw_ok  = ((wr_cnt_ff == '0) || (aw_dec == wr_tgt_ff)) && (wr_cnt_ff < CNT_MAX);
    end

    // Response/ready selection from the owning target
    always_comb begin
        ar_rdy_sel = 1'b0;
        aw_rdy_sel = 1'b0;
        r_vld_sel  = 1'b0;
        r_last_sel = 1'b0;
        r_id_sel   = '0;
        r_data_sel = '0;
        r_resp_sel = '0;
        b_vld_sel  = 1'b0;
        b_id_sel   = '0;
        b_resp_sel = '0;
        for (int i = 0; i <= N_SLAVES; i++) begin
            if (ar_dec == axi_tgt_t'(i)) ar_rdy_sel = tgt_miso[i].arready;
            if (aw_dec == axi_tgt_t'(i)) aw_rdy_sel = tgt_miso[i].awready;
            if (rd_tgt_ff == axi_tgt_t'(i)) begin
                r_vld_sel  = tgt_miso[i].rvalid;
                r_last_sel = tgt_miso[i].rlast;
                r_id_sel   = tgt_miso[i].rid;
                r_data_sel = tgt_miso[i].rdata;
                r_resp_sel = tgt_miso[i].rresp;
            end
            if (wr_tgt_ff == axi_tgt_t'(i)) begin
                b_vld_sel  = tgt_miso[i].bvalid;
                b_id_sel   = tgt_miso[i].bid;
                b_resp_sel = tgt_miso[i].bresp;
            end
        end
    end

    assign ar_hs = mst_axi_mosi_i.arvalid && ar_ok && ar_rdy_sel;
    assign aw_hs = mst_axi_mosi_i.awvalid && aw_ok && aw_rdy_sel;

    // W may only reach a slave that already has (or is just taking) its AW.
    // With nothing pending the W belongs to the AW handshaking right now.
    assign w_open = (w_pend_ff != '0) || aw_hs;
    assign w_tgt  = (w_pend_ff != '0) ? wr_tgt_ff : aw_dec;

    always_comb begin
        w_rdy_sel = 1'b0;
        for (int i = 0; i <= N_SLAVES; i++)
            if (w_tgt == axi_tgt_t'(i)) w_rdy_sel = tgt_miso[i].wready;
    end

    // Fan-out: payload broadcast, valid/ready only to the selected target
    always_comb begin
        for (int i = 0; i <= N_SLAVES; i++) begin
            tgt_mosi[i]         = mst_axi_mosi_i;
            tgt_mosi[i].arvalid = mst_axi_mosi_i.arvalid && ar_ok && (ar_dec == axi_tgt_t'(i));
            tgt_mosi[i].awvalid = mst_axi_mosi_i.awvalid && aw_ok && (aw_dec == axi_tgt_t'(i));
            tgt_mosi[i].wvalid  = mst_axi_mosi_i.wvalid && w_open && (w_tgt == axi_tgt_t'(i));
            tgt_mosi[i].rready  = mst_axi_mosi_i.rready && (rd_tgt_ff == axi_tgt_t'(i));
            tgt_mosi[i].bready  = mst_axi_mosi_i.bready && (wr_tgt_ff == axi_tgt_t'(i));
        end
    end

    assign slv_axi_mosi_o = tgt_mosi[N_SLAVES-1:0];

    always_comb begin
        mst_axi_miso_o         = '0;
        mst_axi_miso_o.arready = ar_hs;
        mst_axi_miso_o.awready = aw_hs;
        mst_axi_miso_o.wready  = mst_axi_mosi_i.wvalid && w_open && w_rdy_sel;
        mst_axi_miso_o.rvalid  = r_vld_sel;
        mst_axi_miso_o.rlast   = r_last_sel;
        mst_axi_miso_o.rid     = r_id_sel;
        mst_axi_miso_o.rdata   = r_data_sel;
        mst_axi_miso_o.rresp   = r_resp_sel;
        mst_axi_miso_o.bvalid  = b_vld_sel;
        mst_axi_miso_o.bid     = b_id_sel;
        mst_axi_miso_o.bresp   = b_resp_sel;
    end

    assign r_done = r_vld_sel && mst_axi_mosi_i.rready && r_last_sel;
    assign w_done = mst_axi_miso_o.wready && mst_axi_mosi_i.wlast;
    assign b_done = b_vld_sel && mst_axi_mosi_i.bready;

    // Outstanding tracking; simultaneous inc/dec leaves a count unchanged
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_cnt_ff <= '0;
            wr_cnt_ff <= '0;
            w_pend_ff <= '0;
            rd_tgt_ff <= '0;
            wr_tgt_ff <= '0;
            dec_err_o <= 1'b0;
        end else begin
            if (ar_hs) rd_tgt_ff <= ar_dec;
            if (aw_hs) wr_tgt_ff <= aw_dec;
            if (ar_hs && !r_done)      rd_cnt_ff <= rd_cnt_ff + cnt_t'(1);
            else if (!ar_hs && r_done) rd_cnt_ff <= rd_cnt_ff - cnt_t'(1);
            if (aw_hs && !b_done)      wr_cnt_ff <= wr_cnt_ff + cnt_t'(1);
            else if (!aw_hs && b_done) wr_cnt_ff <= wr_cnt_ff - cnt_t'(1);
            if (aw_hs && !w_done)      w_pend_ff <= w_pend_ff + cnt_t'(1);
            else if (!aw_hs && w_done) w_pend_ff <= w_pend_ff - cnt_t'(1);
            dec_err_o <= (ar_hs && (ar_dec == DEC_IDX)) || (aw_hs && (aw_dec == DEC_IDX));
        end
    end

    axi_decerr_slave u_decerr (
        .clk        (clk),
        .arst       (arst),
        .axi_mosi_i (tgt_mosi[N_SLAVES]),
        .axi_miso_o (dec_miso)
    );

endmodule

// File: tb/tb_axi_addr_router.sv
module tb_axi_addr_router;
    import nox_utils_pkg::*;

    logic clk = 1'b0;
    logic arst;
    s_axi_mosi_t        m;
    s_axi_miso_t        mo;
    s_axi_mosi_t [2:0]  so;
    s_axi_miso_t [2:0]  si;
    logic               dec_err;

    int ncmp = 0;
    int nerr = 0;

    axi_addr_router dut (
        .clk            (clk),
        .arst           (arst),
        .mst_axi_mosi_i (m),
        .mst_axi_miso_o (mo),
        .slv_axi_mosi_o (so),
        .slv_axi_miso_i (si),
        .dec_err_o      (dec_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst = 1'b1;
        m    = '0;
        si   = '0;
        for (int i = 0; i < 3; i++) begin
            si[i].arready = 1'b1;
            si[i].awready = 1'b1;
            si[i].wready  = 1'b1;
        end
        #12;
        chk("rst_arready", mo.arready, 0);
        chk("rst_rvalid",  mo.rvalid, 0);
        chk("rst_bvalid",  mo.bvalid, 0);
        chk("rst_dec_err", dec_err, 0);
        chk("rst_rd_cnt",  dut.rd_cnt_ff, 0);
        chk("rst_wr_cnt",  dut.wr_cnt_ff, 0);
        chk("rst_w_pend",  dut.w_pend_ff, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        tick();

        // T1: single read to slave 0
        m.arvalid = 1'b1; m.araddr = 32'h8000_0010; m.arid = 4'd1; m.arlen = 8'd0;
        #1;
        chk("t1_slv0_arvalid", so[0].arvalid, 1);
        chk("t1_slv1_arvalid", so[1].arvalid, 0);
        chk("t1_arready",      mo.arready, 1);
        tick();
        m.arvalid = 1'b0;
        #1;
        chk("t1_rd_cnt_1", dut.rd_cnt_ff, 1);
        si[0].rvalid = 1'b1; si[0].rdata = 32'hDEAD_BEEF; si[0].rlast = 1'b1; si[0].rid = 4'd1;
        m.rready = 1'b1;
        #1;
        chk("t1_rvalid",      mo.rvalid, 1);
        chk("t1_rdata",       mo.rdata, 64'hDEAD_BEEF);
        chk("t1_slv0_rready", so[0].rready, 1);
        chk("t1_slv1_rready", so[1].rready, 0);
        tick();
        si[0].rvalid = 1'b0; si[0].rlast = 1'b0; m.rready = 1'b0;
        #1;
        chk("t1_rd_cnt_0", dut.rd_cnt_ff, 0);

        // T2: fill to MAX_OUT on slave 1, fifth AR stalls
        m.arvalid = 1'b1; m.araddr = 32'h1000_0000;
        for (int k = 0; k < 4; k++) begin
            m.arid = 4'(k);
            #1;
            chk("t2_arready_fill", mo.arready, 1);
            tick();
        end
        #1;
        chk("t2_full_arready",   mo.arready, 0);
        chk("t2_full_slv1_arv",  so[1].arvalid, 0);
        chk("t2_rd_cnt_4",       dut.rd_cnt_ff, 4);
        si[1].rvalid = 1'b1; si[1].rlast = 1'b1; m.rready = 1'b1;
        #1;
        chk("t2_full_during_rlast", mo.arready, 0);
        tick();
        si[1].rvalid = 1'b0; m.rready = 1'b0;
        #1;
        chk("t2_rd_cnt_3",     dut.rd_cnt_ff, 3);
        chk("t2_recovered_ar", mo.arready, 1);
        tick();
        m.arvalid = 1'b0;
        #1;
        chk("t2_rd_cnt_refill", dut.rd_cnt_ff, 4);
        si[1].rvalid = 1'b1; si[1].rlast = 1'b1; m.rready = 1'b1;
        repeat (4) tick();
        si[1].rvalid = 1'b0; si[1].rlast = 1'b0; m.rready = 1'b0;
        #1;
        chk("t2_rd_cnt_drained", dut.rd_cnt_ff, 0);

        // T3: target switch waits for the outstanding slave-1 read
        m.arvalid = 1'b1; m.araddr = 32'h1000_0004;
        tick();
        m.araddr = 32'h8000_0000;
        #1;
        chk("t3_slv0_arvalid_held", so[0].arvalid, 0);
        chk("t3_arready_held",      mo.arready, 0);
        chk("t3_rd_tgt_1",          dut.rd_tgt_ff, 1);
        si[0].rvalid = 1'b1; m.rready = 1'b1;
        #1;
        chk("t3_no_slv0_r",   mo.rvalid, 0);
        chk("t3_slv0_rready", so[0].rready, 0);
        si[0].rvalid = 1'b0;
        si[1].rvalid = 1'b1; si[1].rlast = 1'b1; si[1].rdata = 32'h0000_1111;
        #1;
        chk("t3_slv1_rdata",   mo.rdata, 64'h1111);
        chk("t3_arready_late", mo.arready, 0);
        tick();
        si[1].rvalid = 1'b0; si[1].rlast = 1'b0;
        #1;
        chk("t3_arready_free", mo.arready, 1);
        chk("t3_slv0_arvalid", so[0].arvalid, 1);
        tick();
        m.arvalid = 1'b0;
        #1;
        chk("t3_rd_tgt_0", dut.rd_tgt_ff, 0);
        si[0].rvalid = 1'b1; si[0].rlast = 1'b1;
        tick();
        si[0].rvalid = 1'b0; si[0].rlast = 1'b0; m.rready = 1'b0;
        #1;
        chk("t3_rd_cnt_0", dut.rd_cnt_ff, 0);

        // T4: W before AW to slave 2
        m.wvalid = 1'b1; m.wlast = 1'b1; m.wdata = 32'h0000_55AA;
        #1;
        chk("t4_wready_early", mo.wready, 0);
        chk("t4_slv2_wv_early", so[2].wvalid, 0);
        tick();
        m.awvalid = 1'b1; m.awaddr = 32'h2000_0000; m.awid = 4'd3;
        #1;
        chk("t4_awready",     mo.awready, 1);
        chk("t4_slv2_awvalid", so[2].awvalid, 1);
        chk("t4_slv2_wvalid",  so[2].wvalid, 1);
        chk("t4_slv2_wdata",   so[2].wdata, 64'h55AA);
        chk("t4_wready",       mo.wready, 1);
        tick();
        m.awvalid = 1'b0; m.wvalid = 1'b0; m.wlast = 1'b0;
        #1;
        chk("t4_wr_cnt_1",  dut.wr_cnt_ff, 1);
        chk("t4_w_pend_0",  dut.w_pend_ff, 0);
        si[2].bvalid = 1'b1; si[2].bresp = AXI_RESP_OKAY; si[2].bid = 4'd3; m.bready = 1'b1;
        #1;
        chk("t4_bvalid", mo.bvalid, 1);
        chk("t4_bresp",  mo.bresp, 0);
        chk("t4_bid",    mo.bid, 3);
        tick();
        si[2].bvalid = 1'b0; m.bready = 1'b0;
        #1;
        chk("t4_wr_cnt_0", dut.wr_cnt_ff, 0);

        // T5: unmapped read burst and write
        m.arvalid = 1'b1; m.araddr = 32'h4000_0000; m.arlen = 8'd3; m.arid = 4'd5;
        #1;
        chk("t5_arready",      mo.arready, 1);
        chk("t5_slv1_arvalid", so[1].arvalid, 0);
        chk("t5_dec_err_pre",  dec_err, 0);
        tick();
        m.arvalid = 1'b0; m.rready = 1'b1;
        #1;
        chk("t5_dec_err_pulse", dec_err, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t5_rvalid", mo.rvalid, 1);
            chk("t5_rresp",  mo.rresp, 3);
            chk("t5_rdata",  mo.rdata, 0);
            chk("t5_rid",    mo.rid, 5);
            chk("t5_rlast",  mo.rlast, (k == 3) ? 1 : 0);
            tick();
            if (k == 0) chk("t5_dec_err_clear", dec_err, 0);
        end
        m.rready = 1'b0;
        chk("t5_rvalid_done", mo.rvalid, 0);
        chk("t5_rd_cnt_0",    dut.rd_cnt_ff, 0);
        m.awvalid = 1'b1; m.awaddr = 32'h4000_0000; m.awid = 4'd6;
        m.wvalid = 1'b1; m.wlast = 1'b1; m.wdata = '0;
        #1;
        chk("t5_awready",      mo.awready, 1);
        chk("t5_wready_first", mo.wready, 0);
        tick();
        m.awvalid = 1'b0;
        #1;
        chk("t5_wr_dec_err", dec_err, 1);
        chk("t5_w_pend_1",   dut.w_pend_ff, 1);
        chk("t5_wready",     mo.wready, 1);
        tick();
        m.wvalid = 1'b0; m.wlast = 1'b0; m.bready = 1'b1;
        #1;
        chk("t5_bvalid", mo.bvalid, 1);
        chk("t5_bresp",  mo.bresp, 3);
        chk("t5_bid",    mo.bid, 6);
        tick();
        m.bready = 1'b0;
        #1;
        chk("t5_wr_cnt_0",  dut.wr_cnt_ff, 0);
        chk("t5_bvalid_off", mo.bvalid, 0);

        // T6: async reset with two reads outstanding
        m.arvalid = 1'b1; m.araddr = 32'h1000_0000; m.arlen = 8'd0;
        tick();
        tick();
        m.arvalid = 1'b0;
        #1;
        chk("t6_rd_cnt_2", dut.rd_cnt_ff, 2);
        #2;
        arst = 1'b1;
        #1;
        chk("t6_rd_cnt_async", dut.rd_cnt_ff, 0);
        chk("t6_rd_tgt_async", dut.rd_tgt_ff, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        m.arvalid = 1'b1; m.araddr = 32'h8000_0000;
        #1;
        chk("t6_arready_after", mo.arready, 1);
        chk("t6_slv0_arvalid",  so[0].arvalid, 1);
        tick();
        m.arvalid = 1'b0;
        #1;
        chk("t6_rd_cnt_1", dut.rd_cnt_ff, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
